mode_sel_fsm: RTL and testbench

MODE_SEL_FSM -- requirements
Module: mode_sel_fsm

---
 rtl/mode_sel_fsm.sv | 133 +++++++++++++
 tb/tb_mode_sel_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mode_sel_fsm.sv
// Mode selector: steps a binary mode register forward/backward on debounced button edges,
// with direct load, hold, wrap/saturate behaviour and one-hot/at-last decodes.
module mode_sel_fsm #(
    parameter int NUM_MODES  = 3,
    parameter int SEL_W      = 2,
    parameter int WRAP       = 1,
    parameter int RESET_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 back,
    input  logic                 hold,
    input  logic                 load_en,
    input  logic [SEL_W-1:0]     load_val,
    output logic [SEL_W-1:0]     sel_out,
    output logic [NUM_MODES-1:0] sel_onehot,
    output logic                 wrap_pulse,
    output logic                 load_err,
    output logic                 at_last
);

    localparam logic [1:0] STEP_NONE = 2'd0;
    localparam logic [1:0] STEP_FWD  = 2'd1;
    localparam logic [1:0] STEP_BWD  = 2'd2;

    localparam logic [SEL_W-1:0] LAST_MODE = SEL_W'(NUM_MODES - 1);
    localparam logic [SEL_W-1:0] INIT_MODE = SEL_W'(RESET_MODE);
    localparam logic [NUM_MODES-1:0] ONE_HOT_BASE = NUM_MODES'(1);

    logic             adv_q_r;
    logic             back_q_r;
    logic [1:0]       step_r;
    logic [SEL_W-1:0] mode_r;
    logic             wrap_r;
    logic             err_r;

    logic             adv_rise_s;
    logic             back_rise_s;
    logic             load_ok_s;
    logic [1:0]       step_next_s;
    logic [SEL_W-1:0] mode_next_s;
    logic             wrap_next_s;
    logic             err_next_s;

    assign adv_rise_s  = adv & ~adv_q_r;
    assign back_rise_s = back & ~back_q_r;
    assign load_ok_s   = (32'(load_val) < 32'(NUM_MODES));

    // Decide which step (if any) a freshly sampled edge requests; applied on the next edge.
    always_comb begin
        step_next_s = STEP_NONE;
        if (load_en || hold || (adv_rise_s && back_rise_s)) begin
            step_next_s = STEP_NONE;
        end else if (adv_rise_s) begin
            step_next_s = STEP_FWD;
        end else if (back_rise_s) begin
            step_next_s = STEP_BWD;
        end else begin
            step_next_s = STEP_NONE;
        end
    end

    // Next mode: a load overrides any pending step; stepping wraps or saturates at the ends.
    always_comb begin
        mode_next_s = mode_r;
        wrap_next_s = 1'b0;
        err_next_s  = 1'b0;
        if (load_en) begin
            if (load_ok_s) begin
                mode_next_s = load_val;
            end else begin
                err_next_s = 1'b1;
            end
        end else begin
            case (step_r)
                STEP_FWD: begin
                    if (mode_r >= LAST_MODE) begin
                        if (WRAP != 0) begin
                            mode_next_s = {SEL_W{1'b0}};
                            wrap_next_s = 1'b1;
                        end else begin
                            mode_next_s = LAST_MODE;
                        end
                    end else begin
                        mode_next_s = mode_r + SEL_W'(1);
                    end
                end
                STEP_BWD: begin
                    if (mode_r == {SEL_W{1'b0}}) begin
                        if (WRAP != 0) begin
                            mode_next_s = LAST_MODE;
                            wrap_next_s = 1'b1;
                        end else begin
                            mode_next_s = {SEL_W{1'b0}};
                        end
                    end else begin
                        mode_next_s = mode_r - SEL_W'(1);
                    end
                end
                default: begin
                    mode_next_s = mode_r;
                end
            endcase
        end
    end

    // State registers; reset discards pending steps and pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adv_q_r  <= 1'b0;
            back_q_r <= 1'b0;
            step_r   <= STEP_NONE;
            mode_r   <= INIT_MODE;
            wrap_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            adv_q_r  <= adv;
            back_q_r <= back;
            step_r   <= step_next_s;
            mode_r   <= mode_next_s;
            wrap_r   <= wrap_next_s;
            err_r    <= err_next_s;
        end
    end

    assign sel_out    = mode_r;
    assign sel_onehot = ONE_HOT_BASE << mode_r;
    assign at_last    = (mode_r == LAST_MODE);
    assign wrap_pulse = wrap_r;
    assign load_err   = err_r;

endmodule

// File: tb/tb_mode_sel_fsm.sv
// Bench for mode_sel_fsm: two configurations checked each cycle against a behavioural model,
// plus directed sequences with literal expectations.
module tb_mode_sel_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       adv = 1'b0;
    logic       back = 1'b0;
    logic       hold = 1'b0;
    logic       load_en = 1'b0;
    logic [2:0] lv = 3'd0;

    logic [1:0] sel0;
    logic [2:0] oh0;
    logic       wp0, le0, al0;
    logic [2:0] sel1;
    logic [4:0] oh1;
    logic       wp1, le1, al1;

    int nchk = 0;
    int nerr = 0;

    // Model state: index 0 = defaults (3 modes, wrap, reset 0), 1 = 5 modes, saturate, reset 1
    int nm[2]  = '{3, 5};
    int wr[2]  = '{1, 0};
    int rm[2]  = '{0, 1};
    int m[2];
    int pend[2];
    int mw[2];
    int me[2];
    bit pa, pb;

    mode_sel_fsm u0 (
        .clk(clk), .rst(rst), .adv(adv), .back(back), .hold(hold),
        .load_en(load_en), .load_val(lv[1:0]),
        .sel_out(sel0), .sel_onehot(oh0), .wrap_pulse(wp0), .load_err(le0), .at_last(al0)
    );

    mode_sel_fsm #(.NUM_MODES(5), .SEL_W(3), .WRAP(0), .RESET_MODE(1)) u1 (
        .clk(clk), .rst(rst), .adv(adv), .back(back), .hold(hold),
        .load_en(load_en), .load_val(lv),
        .sel_out(sel1), .sel_onehot(oh1), .wrap_pulse(wp1), .load_err(le1), .at_last(al1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nme, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nme, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i] = rm[i]; pend[i] = 0; mw[i] = 0; me[i] = 0;
        end
        pa = 1'b0; pb = 1'b0;
    endtask

    initial model_reset();
    always @(negedge rst) model_reset();

    // Behavioural model: an edge seen at one clock moves the mode on the following clock.
    always @(posedge clk) begin
        if (rst) begin
            bit ra, rb;
            ra = adv && !pa;
            rb = back && !pb;
            for (int i = 0; i < 2; i++) begin
                int val;
                val = (i == 0) ? int'(lv[1:0]) : int'(lv);
                mw[i] = 0; me[i] = 0;
                if (load_en) begin
                    if (val < nm[i]) m[i] = val;
                    else me[i] = 1;
                end else if (pend[i] == 1) begin
                    if (m[i] < nm[i] - 1) m[i] = m[i] + 1;
                    else if (wr[i] != 0) begin m[i] = 0; mw[i] = 1; end
                end else if (pend[i] == -1) begin
                    if (m[i] > 0) m[i] = m[i] - 1;
                    else if (wr[i] != 0) begin m[i] = nm[i] - 1; mw[i] = 1; end
                end
                if (load_en || hold || (ra && rb)) pend[i] = 0;
                else if (ra) pend[i] = 1;
                else if (rb) pend[i] = -1;
                else pend[i] = 0;
            end
            pa = adv; pb = back;
        end
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        chk("u0.sel_out", int'(sel0), m[0]);
        chk("u0.sel_onehot", int'(oh0), 1 << m[0]);
        chk("u0.wrap_pulse", int'(wp0), mw[0]);
        chk("u0.load_err", int'(le0), me[0]);
        chk("u0.at_last", int'(al0), int'(m[0] == nm[0] - 1));
        chk("u1.sel_out", int'(sel1), m[1]);
        chk("u1.sel_onehot", int'(oh1), 1 << m[1]);
        chk("u1.wrap_pulse", int'(wp1), mw[1]);
        chk("u1.load_err", int'(le1), me[1]);
        chk("u1.at_last", int'(al1), int'(m[1] == nm[1] - 1));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit a, input bit b);
        adv = a; back = b;
        cyc(1);
        adv = 1'b0; back = 1'b0;
        cyc(1);
    endtask

    task automatic load(input int v);
        load_en = 1'b1; lv = 3'(v);
        cyc(1);
        load_en = 1'b0;
    endtask

    initial begin
        // Reset released with adv already high: exactly one step
        adv = 1'b1;
        cyc(2);
        rst = 1'b1;
        chk("lit_reset_u0", int'(sel0), 0);
        chk("lit_reset_u1", int'(sel1), 1);
        chk("lit_reset_oh1", int'(oh1), 2);
        cyc(1);
        chk("lit_latency_u0", int'(sel0), 0);
        cyc(1);
        chk("lit_step_u0", int'(sel0), 1);
        cyc(4);
        chk("lit_held_u0", int'(sel0), 1);
        chk("lit_held_u1", int'(sel1), 2);
        adv = 1'b0;
        load(0);

        // Backward at mode 0: wrap on defaults, saturate on the WRAP=0 instance
        pulse(1'b0, 1'b1);
        chk("lit_back_wrap_u0", int'(sel0), 2);
        chk("lit_back_wp_u0", int'(wp0), 1);
        chk("lit_back_sat_u1", int'(sel1), 0);
        chk("lit_back_wp_u1", int'(wp1), 0);
        load(0);

        pulse(1'b1, 1'b0);
        chk("lit_adv1_u0", int'(sel0), 1);
        chk("lit_adv1_last", int'(al0), 0);
        pulse(1'b1, 1'b0);
        chk("lit_adv2_u0", int'(sel0), 2);
        chk("lit_adv2_last", int'(al0), 1);
        chk("lit_adv2_wp", int'(wp0), 0);
        pulse(1'b1, 1'b0);
        chk("lit_adv3_u0", int'(sel0), 0);
        chk("lit_adv3_wp", int'(wp0), 1);
        chk("lit_adv3_last", int'(al0), 0);
        cyc(1);
        chk("lit_wp_drop", int'(wp0), 0);
        pulse(1'b1, 1'b0);
        chk("lit_u1_4", int'(sel1), 4);
        pulse(1'b1, 1'b0);
        chk("lit_u1_sat", int'(sel1), 4);
        chk("lit_u1_sat_wp", int'(wp1), 0);

        // Illegal load on the 3-mode instance
        load(3);
        chk("lit_badload_sel", int'(sel0), 2);
        chk("lit_badload_err", int'(le0), 1);
        chk("lit_goodload_u1", int'(sel1), 3);
        cyc(1);
        chk("lit_err_drop", int'(le0), 0);

        // Load coinciding with an adv rise: load wins, the rise is dropped
        adv = 1'b1; load_en = 1'b1; lv = 3'd2;
        cyc(1);
        load_en = 1'b0;
        chk("lit_load_adv", int'(sel0), 2);
        cyc(2);
        chk("lit_load_nostep", int'(sel0), 2);
        adv = 1'b0;
        cyc(1);

        // Hold discards edges; simultaneous adv+back does nothing
        hold = 1'b1;
        pulse(1'b1, 1'b0);
        hold = 1'b0;
        cyc(3);
        chk("lit_hold_u0", int'(sel0), 2);
        pulse(1'b1, 1'b1);
        cyc(1);
        chk("lit_both_u0", int'(sel0), 2);
        chk("lit_both_u1", int'(sel1), 2);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("lit_async_u1", int'(sel1), 1);
        chk("lit_async_oh1", int'(oh1), 2);
        chk("lit_async_u0", int'(sel0), 0);
        chk("lit_async_oh0", int'(oh0), 1);
        @(negedge clk);
        rst = 1'b1;

        // Randomised phase
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) adv = ~adv;
            if ($urandom_range(0, 2) == 0) back = ~back;
            hold    = ($urandom_range(0, 4) == 0);
            load_en = ($urandom_range(0, 9) == 0);
            lv      = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
